// File: rtl/sseg_display_ctrl_if.sv
// Request/display bundle for the 7-segment display controller.
// The requester drives the load strobe and value fields; the controller
// returns its status flags and the scanned anode/segment lines.
interface sseg_display_ctrl_if #(
    parameter int W        = 32,
    parameter int N_DIGITS = 8
);
    logic                load;
    logic [W-1:0]        value;
    logic                mode;
    logic                blank_lz;
    logic                busy;
    logic                overflow;
    logic [N_DIGITS-1:0] anodes;
    logic [6:0]          segments;

    modport master (
        output load, value, mode, blank_lz,
        input  busy, overflow, anodes, segments
    );

    modport slave (
        input  load, value, mode, blank_lz,
        output busy, overflow, anodes, segments
    );
endinterface

// File: rtl/sseg_display_ctrl.sv
// N-digit multiplexed 7-segment display controller.
// A value latched on load is shown either as hex nibbles or, after a
// W-cycle sequential double-dabble conversion, as unsigned decimal.
// Leading-zero blanking and an all-dash overflow display are supported.
// Digits are scanned one at a time on active-low anodes; anodes and
// segments are registered together so they always describe the same digit.
module sseg_display_ctrl #(
    parameter int W              = 32,
    parameter int N_DIGITS       = 8,
    parameter int REFRESH_CYCLES = 50000
) (
    input  logic                  clk,
    input  logic                  reset,
    sseg_display_ctrl_if.slave    bus
);
    // Decimal digits needed for 2^W-1 (floor(W*log10(2)) + 1).
    localparam int BCD_DIGITS = (W * 30103) / 100000 + 1;
    localparam int BUF_DIGITS = (BCD_DIGITS > N_DIGITS) ? BCD_DIGITS : N_DIGITS;
    localparam int BCD_W      = 4 * BUF_DIGITS;
    localparam int DISP_W     = 4 * N_DIGITS;
    localparam int XW         = (W > DISP_W) ? W : DISP_W;
    localparam int CNT_W      = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int IDX_W      = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int ITER_W     = (W > 1) ? $clog2(W) : 1;

    typedef enum logic {IDLE, CONVERT} state_t;

    state_t              state_q, state_d;
    logic                accept, last_iter;
    logic [ITER_W-1:0]   iter_q;
    logic                blank_pend_q;

    logic [W-1:0]        bin_q;
    logic [BCD_W-1:0]    bcd_q, bcd_adj, bcd_shift;
    logic [XW-1:0]       value_ext;
    logic [DISP_W-1:0]   hex_buf, dec_buf;
    logic                hex_ovf, dec_ovf;

    logic [DISP_W-1:0]   disp_q;
    logic                ovf_q, blank_q;
    logic [N_DIGITS-1:0] blank_mask;

    logic [CNT_W-1:0]    cnt_q;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                cnt_last;
    logic [3:0]          nibble;
    logic [6:0]          seg_d;
    logic [N_DIGITS-1:0] anodes_p1;
    logic [6:0]          segments_p1;

    // Active-low glyph for one hex digit.
    function automatic logic [6:0] hex_glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'h0: g = 7'h40;  4'h1: g = 7'h79;  4'h2: g = 7'h24;  4'h3: g = 7'h30;
            4'h4: g = 7'h19;  4'h5: g = 7'h12;  4'h6: g = 7'h02;  4'h7: g = 7'h78;
            4'h8: g = 7'h00;  4'h9: g = 7'h10;  4'hA: g = 7'h08;  4'hB: g = 7'h03;
            4'hC: g = 7'h46;  4'hD: g = 7'h21;  4'hE: g = 7'h06;  default: g = 7'h0E;
        endcase
        return g;
    endfunction

    // Double-dabble correction: add 3 to every BCD digit that is 5 or more.
    function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < BUF_DIGITS; i++) begin
            if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    // Next-state logic: accept loads only when idle, finish after W iterations.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        last_iter = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.load) begin
                    accept = 1'b1;
                    if (bus.mode) state_d = CONVERT;
                end
            end
            CONVERT: begin
                if (iter_q == ITER_W'(W - 1)) begin
                    last_iter = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state, iteration counter and the pending blanking choice.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            iter_q       <= '0;
            blank_pend_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                iter_q       <= '0;
                blank_pend_q <= bus.blank_lz;
            end else if (state_q == CONVERT) begin
                iter_q <= iter_q + ITER_W'(1);
            end
        end
    end

    // Hex and decimal candidates for the display buffer.
    always_comb begin
        value_ext = XW'(bus.value);
        hex_buf   = value_ext[DISP_W-1:0];
        hex_ovf   = |(value_ext >> DISP_W);
        bcd_adj   = dabble_adjust(bcd_q);
        bcd_shift = (bcd_adj << 1) | BCD_W'(bin_q[W-1]);
        dec_buf   = bcd_shift[DISP_W-1:0];
        dec_ovf   = |(bcd_shift >> DISP_W);
    end

    // Converter shift registers; only meaningful while converting, so no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            bin_q <= bus.value;
            bcd_q <= '0;
        end else if (state_q == CONVERT) begin
            bin_q <= bin_q << 1;
            bcd_q <= bcd_shift;
        end
    end

    // Display buffer commit: hex on the accepting edge, decimal on the last iteration.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            disp_q  <= '0;
            ovf_q   <= 1'b0;
            blank_q <= 1'b0;
        end else if (accept && !bus.mode) begin
            disp_q  <= hex_buf;
            ovf_q   <= hex_ovf;
            blank_q <= bus.blank_lz;
        end else if (last_iter) begin
            disp_q  <= dec_buf;
            ovf_q   <= dec_ovf;
            blank_q <= blank_pend_q;
        end
    end

    // Leading-zero mask: digit i blanks when it and every digit above it are zero.
    always_comb begin
        logic above_zero;
        blank_mask = '0;
        above_zero = 1'b1;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            above_zero    = above_zero & (disp_q[4*i +: 4] == 4'd0);
            blank_mask[i] = blank_q & above_zero;
        end
    end

    // Scan index for the coming cycle and the glyph it will display.
    always_comb begin
        cnt_last = (cnt_q == CNT_W'(REFRESH_CYCLES - 1));
        idx_d    = idx_q;
        if (cnt_last) idx_d = (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        nibble = disp_q[{idx_d, 2'b00} +: 4];
        if (ovf_q)                  seg_d = 7'h3F;
        else if (blank_mask[idx_d]) seg_d = 7'h7F;
        else                        seg_d = hex_glyph(nibble);
    end

    // Refresh counter, scan index and the registered anode/segment outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q       <= '0;
            idx_q       <= '0;
            anodes_p1   <= ~N_DIGITS'(1);
            segments_p1 <= 7'h40;
        end else begin
            cnt_q       <= cnt_last ? '0 : cnt_q + CNT_W'(1);
            idx_q       <= idx_d;
            anodes_p1   <= ~(N_DIGITS'(1) << idx_d);
            segments_p1 <= seg_d;
        end
    end

    assign bus.busy     = (state_q == CONVERT);
    assign bus.overflow = ovf_q;
    assign bus.anodes   = anodes_p1;
    assign bus.segments = segments_p1;

endmodule

// File: tb/tb_sseg_display_ctrl.sv
// Directed bench for sseg_display_ctrl: reset, scan order, hex and decimal
// display, load dropping while busy, blanking, overflow and mid-conversion reset.
module tb_sseg_display_ctrl;
    localparam int W  = 32;
    localparam int ND = 8;
    localparam int RC = 2;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic mon_en;
    logic busy_seen;

    sseg_display_ctrl_if #(.W(W), .N_DIGITS(ND)) bus ();

    sseg_display_ctrl #(.W(W), .N_DIGITS(ND), .REFRESH_CYCLES(RC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Exactly one anode low on every cycle.
    always @(negedge clk) begin
        if (mon_en) check_eq("onehot", 32'($onehot(~bus.anodes)), 32'd1);
        if (bus.busy) busy_seen = 1'b1;
    end

    task automatic do_load(input logic [W-1:0] v, input logic m, input logic b);
        @(negedge clk);
        bus.load = 1'b1; bus.value = v; bus.mode = m; bus.blank_lz = b;
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    // Decimal load; counts busy cycles, optionally re-loads at busy cycle 5.
    task automatic load_dec(input logic [W-1:0] v, input logic b, input logic inject,
                            output int busy_cycles);
        do_load(v, 1'b1, b);
        busy_cycles = 0;
        while (bus.busy && busy_cycles < 100) begin
            busy_cycles++;
            if (inject && busy_cycles == 5) begin
                bus.load = 1'b1; bus.value = 32'd5; bus.mode = 1'b1; bus.blank_lz = 1'b1;
            end else begin
                bus.load = 1'b0;
            end
            @(negedge clk);
        end
        bus.load = 1'b0;
    endtask

    task automatic sweep(input string name, input logic [6:0] exp [ND]);
        logic [6:0] seen [ND];
        for (int d = 0; d < ND; d++) seen[d] = 7'h55;
        repeat (2) @(negedge clk);
        repeat (2 * ND * RC) begin
            @(negedge clk);
            for (int d = 0; d < ND; d++) if (!bus.anodes[d]) seen[d] = bus.segments;
        end
        for (int d = 0; d < ND; d++)
            check_eq($sformatf("%s_d%0d", name, d), 32'(seen[d]), 32'(exp[d]));
    endtask

    logic [6:0] exp_hex  [ND] = '{7'h21, 7'h46, 7'h03, 7'h08, 7'h19, 7'h30, 7'h24, 7'h79};
    logic [6:0] exp_dec  [ND] = '{7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};
    logic [6:0] exp_42   [ND] = '{7'h24, 7'h19, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    logic [6:0] exp_0    [ND] = '{7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    logic [6:0] exp_dash [ND] = '{7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
    logic [6:0] exp_9    [ND] = '{7'h10, 7'h10, 7'h10, 7'h10, 7'h10, 7'h10, 7'h10, 7'h10};
    logic [6:0] exp_zero [ND] = '{7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
    logic [6:0] exp_rev  [ND] = '{7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00};
    logic [7:0] exp_scan [8]  = '{8'hFE, 8'hFD, 8'hFD, 8'hFB, 8'hFB, 8'hF7, 8'hF7, 8'hEF};

    initial begin
        int bc;
        checks = 0; errors = 0; mon_en = 1'b0; busy_seen = 1'b0;
        bus.load = 1'b0; bus.value = '0; bus.mode = 1'b0; bus.blank_lz = 1'b0;
        reset = 1'b1;
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_anodes", 32'(bus.anodes), 32'hFE);
        check_eq("rst_segments", 32'(bus.segments), 32'h40);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_ovf", 32'(bus.overflow), 32'd0);
        reset = 1'b1;
        mon_en = 1'b1;

        // Reset during scan, then check the scan order after release.
        repeat (5) @(negedge clk);
        @(posedge clk); #1 reset = 1'b0;
        #1;
        check_eq("midscan_anodes", 32'(bus.anodes), 32'hFE);
        check_eq("midscan_segments", 32'(bus.segments), 32'h40);
        check_eq("midscan_busy", 32'(bus.busy), 32'd0);
        @(negedge clk); reset = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check_eq($sformatf("scan_%0d", k), 32'(bus.anodes), 32'(exp_scan[k]));
        end

        // Hex display.
        busy_seen = 1'b0;
        do_load(32'h1234ABCD, 1'b0, 1'b0);
        sweep("hex", exp_hex);
        check_eq("hex_busy", 32'(busy_seen), 32'd0);
        check_eq("hex_ovf", 32'(bus.overflow), 32'd0);

        // Decimal with a dropped second load.
        load_dec(32'd12345678, 1'b0, 1'b1, bc);
        check_eq("dec_busy_cycles", 32'(bc), 32'd32);
        sweep("dec", exp_dec);
        check_eq("dec_ovf", 32'(bus.overflow), 32'd0);

        // Leading-zero blanking.
        load_dec(32'd42, 1'b1, 1'b0, bc);
        sweep("lz42", exp_42);
        load_dec(32'd0, 1'b1, 1'b0, bc);
        sweep("lz0", exp_0);

        // Overflow boundary.
        load_dec(32'd100000000, 1'b0, 1'b0, bc);
        check_eq("ovf_set", 32'(bus.overflow), 32'd1);
        sweep("ovf", exp_dash);
        load_dec(32'd99999999, 1'b0, 1'b0, bc);
        check_eq("ovf_clr", 32'(bus.overflow), 32'd0);
        sweep("nines", exp_9);

        // Reset ten cycles into a conversion.
        do_load(32'd12345678, 1'b1, 1'b0);
        repeat (10) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check_eq("abort_busy", 32'(bus.busy), 32'd0);
        check_eq("abort_ovf", 32'(bus.overflow), 32'd0);
        check_eq("abort_segments", 32'(bus.segments), 32'h40);
        @(negedge clk); reset = 1'b1;
        sweep("abort", exp_zero);
        load_dec(32'd87654321, 1'b0, 1'b0, bc);
        check_eq("after_abort_busy_cycles", 32'(bc), 32'd32);
        sweep("after_abort", exp_rev);

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sseg_display_ctrl.md
Name: sseg_display_ctrl

Overview:
- Parametrised N-digit 7-segment display controller. Successor to the 4-digit hex-only display stage behind the ALU/register front end.
- Latches a W-bit value on a load strobe and shows it in hex, or in decimal via a sequential double-dabble converter.
- Optional leading-zero blanking and overflow indication.
- Scans one digit at a time through active-low anodes for the board display and the sseg decoder bench model.

Parameters:
- W, 32, width of the input value.
- N_DIGITS, 8, number of physical digits (and anode lines).
- REFRESH_CYCLES, 50000, clk cycles each digit stays enabled (≥1; benches use 2).

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- load  input  1  one-cycle request to display value.
- value  input  W  number to display; sampled with load.
- mode  input  1  0 = hex, 1 = unsigned decimal; sampled with load.
- blank_lz  input  1  1 = blank leading zero digits; sampled with load.
- busy  output  1  decimal conversion in progress.
- overflow  output  1  committed value does not fit in N_DIGITS digits.
- anodes  output  N_DIGITS  active-low digit enables; exactly one low at all times.
- segments  output  7  active-low; bit0 = a … bit6 = g.

Behaviour:
- Reset (reset = 0, asynchronous), applies at any time including mid-conversion:
  - Conversion aborted; display buffer cleared to all zero digits.
  - busy = 0, overflow = 0, scan index = 0, refresh counter = 0.
  - anodes = ~1 (digit 0 on), segments = 7'h40.
- Load acceptance:
  - load is accepted only when busy = 0 at the sampling edge.
  - load while busy = 1 is dropped; no queue, no error flag.
  - value, mode and blank_lz are captured on the accepting edge.
- Hex mode:
  - Display buffer, blanking mode and overflow commit on the accepting edge (latency 1).
  - busy stays 0.
  - overflow = 1 iff W > 4*N_DIGITS and any bit above 4*N_DIGITS-1 is set.
- Decimal mode, states IDLE, CONVERT:
  - On the accepting edge go to CONVERT; busy = 1 from the next cycle.
  - The converter runs exactly W shift-add-3 iterations, one per clock.
  - On the W-th iteration edge: buffer, overflow and blanking commit, busy returns to 0, state returns to IDLE. busy is high for exactly W cycles.
  - The internal BCD register holds any value up to 2^W-1.
  - overflow = 1 iff the value ≥ 10^N_DIGITS.
  - The old display content stays visible throughout the conversion.
- Overflow display: all digits show dash 7'h3F. overflow persists until the next commit.
- Leading-zero blanking:
  - With blank_lz captured = 1, every digit above the most significant nonzero digit shows 7'h7F.
  - Digit 0 is never blanked, so value 0 shows "0".
  - Blanked digits are still scanned; their anode still goes low.
- Scan:
  - Refresh counter counts 0..REFRESH_CYCLES-1.
  - At terminal count, the counter wraps to 0 and the scan index advances, wrapping N_DIGITS-1 → 0.
  - anodes and segments are registered on the same edge, so they always refer to the same digit (no ghosting).
  - A commit shows its new content from the edge after the commit.
- Hex glyphs, active-low:
  - 0–7: 40, 79, 24, 30, 19, 12, 02, 78
  - 8–F: 00, 10, 08, 03, 46, 21, 06, 0E
  - Special: dash 3F, blank 7F.
- Digit i displays nibble i (hex) or BCD digit i (decimal); digit 0 is least significant.

Test Plan:
- Reset during scan → anodes = 8'hFE, segments = 7'h40, busy = 0, overflow = 0. After release, anodes one-hot every cycle and index advances every REFRESH_CYCLES.
- Hex load 32'h1234ABCD, then sweep all 8 digits:
  - digit0 = 7'h21, digit3 = 7'h08, digit7 = 7'h79.
  - busy never rises; an assertion checks onehot(~anodes) each cycle.
- Decimal load 32'd12345678:
  - busy high for exactly 32 cycles.
  - Digits 0..7 show 8,7,6,5,4,3,2,1 (00, 78, 02, 12, 19, 30, 24, 79).
  - A second load at busy cycle 5 is ignored.
- Decimal 42 with blank_lz = 1 → digit0 = 7'h24, digit1 = 7'h19, digits 2..7 = 7'h7F. Decimal 0 with blank_lz = 1 → digit0 = 7'h40, others 7'h7F.
- Decimal 32'd100000000 → overflow = 1, all digits 7'h3F. Then decimal 99999999 → overflow = 0, all digits 7'h10.
- Reset asserted 10 cycles into a decimal conversion → busy = 0 immediately, all digits 7'h40. The next load completes normally.
